fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Drains the wide first-word-fall-through FIFO written by the narrow-to-wide adapter stage.
- Converts its contents into fixed-length memory write bursts: one command beat (address, length), then a data phase with valid/ready/last.
- Sits directly downstream of the adapter FIFO's read port and upstream of the memory write master.
- Advances a wrapping ring-buffer address after every completed burst.

Parameters:
- DATA_WIDTH, 128, width of FIFO read data and wr_data.
- ADDR_WIDTH, 8, FIFO depth log2; fifo_dat_cnt is ADDR_WIDTH+1 bits.
- BURST_LEN, 16, beats per burst, 1..256, must be <= 2**ADDR_WIDTH.
- MEM_ADDR_WIDTH, 32, byte address width.
- BASE_ADDR, 0, ring start byte address, burst-aligned.
- REGION_BYTES, 1048576, ring size in bytes, multiple of BURST_LEN*DATA_WIDTH/8.
- FLUSH_TIMEOUT, 1024, idle cycles before a partial flush (used only with the macro).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  permits new bursts to start.
- fifo_rd_ena  out  1  pop strobe to the FWFT FIFO.
- fifo_rd_dat  in  DATA_WIDTH  FWFT head word.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_dat_cnt  in  ADDR_WIDTH+1  FIFO occupancy.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  command accepted.
- cmd_addr  out  MEM_ADDR_WIDTH  burst byte address.
- cmd_len  out  8  beats minus one.
- wr_valid  out  1  data beat valid.
- wr_ready  in  1  data beat accepted.
- wr_data  out  DATA_WIDTH  beat data.
- wr_last  out  1  final beat of burst.
- busy  out  1  state is not IDLE.
- burst_cnt  out  32  completed bursts, wraps at 2**32.

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to IDLE; address to BASE_ADDR; beat counter, burst_cnt and flush timer to 0.
  - cmd_valid, wr_valid, wr_last, fifo_rd_ena and busy read 0; cmd_addr reads BASE_ADDR; cmd_len reads 0.
  - A burst in progress is abandoned; no resume after reset.
- State machine has three states: IDLE, CMD, DATA.
- IDLE:
  - When enable=1 and fifo_dat_cnt >= BURST_LEN, go to CMD next cycle.
  - Latch cmd_len = BURST_LEN-1 (8-bit, so BURST_LEN=256 gives 255).
- CMD:
  - cmd_valid=1 (registered). cmd_addr and cmd_len are held stable until cmd_ready=1.
  - On the cycle cmd_valid & cmd_ready, go to DATA and clear the beat counter.
  - A command is never withdrawn. Deasserting enable has no effect once CMD is entered.
- DATA:
  - wr_valid = ~fifo_rd_empty (combinational).
  - wr_data = fifo_rd_dat (combinational, zero added latency).
  - fifo_rd_ena = wr_valid & wr_ready; exactly one pop per accepted beat.
  - wr_last = wr_valid & (beat == latched len).
  - On each handshake the beat counter increments.
  - On the handshake with wr_last:
    - return to IDLE;
    - burst_cnt += 1;
    - address += (len+1)*DATA_WIDTH/8;
    - if the new address >= BASE_ADDR+REGION_BYTES, it wraps to BASE_ADDR.
  - wr_ready low stalls with all outputs held.
  - An empty FIFO mid-burst (only possible with external FIFO misuse) drops wr_valid without skipping beats.
- Back-to-back bursts: at least one IDLE cycle between the last beat and the next cmd_valid.
- Data beats never precede command acceptance. Only one burst is outstanding at a time.
- fifo_rd_ena is 0 in IDLE and CMD.

Optional Feature:
- Macro: FIFO_BURST_READER_FLUSH_EN.
- Defined:
  - In IDLE with enable=1 and 0 < fifo_dat_cnt < BURST_LEN, the flush timer counts cycles.
  - The timer resets whenever these conditions fail or a burst starts.
  - When the timer reaches FLUSH_TIMEOUT, go to CMD with cmd_len = fifo_dat_cnt-1 (snapshot taken at the CMD transition).
  - After the short burst completes, the address advances by the short length, still wrapped.
- Not defined:
  - The timer is absent; only full BURST_LEN bursts are issued.
  - Residual data below BURST_LEN remains in the FIFO indefinitely.

Test Plan:
- Reset, then fifo_dat_cnt=15 with BURST_LEN=16 → no cmd_valid for 100 cycles; busy=0.
- 32 words queued, cmd_ready and wr_ready tied to 1 → two bursts:
  - addr 0x0 and 0x100, cmd_len=15;
  - 16 beats each, wr_last on beats 16 and 32;
  - burst_cnt=2; 32 pops in data order.
- Random wr_ready (50%) and cmd_ready delayed 5 cycles → cmd_addr and cmd_len stable while waiting; data order preserved; no extra or missing pops.
- REGION_BYTES=512, BURST_LEN=16, DATA_WIDTH=128 → burst addresses 0x0, 0x100, 0x0 (wrap).
- rstn low after beat 7 of 16 → outputs zero immediately; after release, the next burst starts at BASE_ADDR and burst_cnt=0.
- With FIFO_BURST_READER_FLUSH_EN, FLUSH_TIMEOUT=8, 5 words held → after 8 idle cycles cmd_len=4, five beats, wr_last on the fifth beat; without the macro, no command is issued.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Drains a wide FWFT FIFO into fixed-length memory write bursts on a wrapping ring.
// Optional partial flush after an idle timeout: define FIFO_BURST_READER_FLUSH_EN.
module fifo_burst_reader #(
  parameter int                  DATA_WIDTH     = 128,
  parameter int                  ADDR_WIDTH     = 8,
  parameter int                  BURST_LEN      = 16,
  parameter int                  MEM_ADDR_WIDTH = 32,
  parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter longint unsigned     REGION_BYTES   = 1048576,
  parameter int                  FLUSH_TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      enable,
  output logic                      fifo_rd_ena,
  input  logic [DATA_WIDTH-1:0]     fifo_rd_dat,
  input  logic                      fifo_rd_empty,
  input  logic [ADDR_WIDTH:0]       fifo_dat_cnt,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [MEM_ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]                cmd_len,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_last,
  output logic                      busy,
  output logic [31:0]               burst_cnt
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int AW1        = MEM_ADDR_WIDTH + 1;

  localparam logic [AW1-1:0]        RING_END = {1'b0, BASE_ADDR} + AW1'(REGION_BYTES);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(BURST_LEN);
  localparam logic [7:0]            FULL_LEN = 8'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > 256 || BURST_LEN > (1 << ADDR_WIDTH)) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN out of range");
  end
  if (REGION_BYTES % (BURST_LEN * BEAT_BYTES) != 0) begin : g_bad_region
    $error("fifo_burst_reader: REGION_BYTES not a multiple of the burst size");
  end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: FLUSH_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [31:0]               burst_cnt_q;

  logic                      start_full;
  logic                      flush_go;
  logic                      cmd_hs;
  logic                      wr_hs;
  logic                      last_hs;
  logic [AW1-1:0]            burst_bytes;
  logic [AW1-1:0]            addr_sum;
  logic [MEM_ADDR_WIDTH-1:0] addr_next;

  assign start_full = (state == IDLE) && enable && (fifo_dat_cnt >= FULL_CNT);

`ifdef FIFO_BURST_READER_FLUSH_EN
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

  logic [TW-1:0] flush_timer;
  logic          flush_arm;

  assign flush_arm = (state == IDLE) && enable && (fifo_dat_cnt != '0) &&
                     (fifo_dat_cnt < FULL_CNT);
  // The cycle the timer would reach FLUSH_TIMEOUT is the cycle the flush launches.
  assign flush_go  = flush_arm && (flush_timer == TW'(FLUSH_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_timer <= '0;
    end else if (flush_arm && !flush_go) begin
      flush_timer <= flush_timer + 1'b1;
    end else begin
      flush_timer <= '0;
    end
  end
`else
  assign flush_go = 1'b0;
`endif

  assign cmd_hs  = (state == CMD) && cmd_ready;
  assign wr_hs   = (state == DATA) && !fifo_rd_empty && wr_ready;
  assign last_hs = wr_hs && (beat_q == len_q);

  // Ring advance computed one bit wider so the end-of-region compare cannot overflow.
  assign burst_bytes = (AW1'(len_q) + AW1'(1)) * AW1'(BEAT_BYTES);
  assign addr_sum    = {1'b0, addr_q} + burst_bytes;
  assign addr_next   = (addr_sum >= RING_END) ? BASE_ADDR : addr_sum[MEM_ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_full || flush_go) begin
          next_state = CMD;
        end
      end
      CMD: begin
        if (cmd_ready) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (last_hs) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= BASE_ADDR;
      len_q       <= '0;
      beat_q      <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (start_full) begin
        len_q <= FULL_LEN;
      end else if (flush_go) begin
        len_q <= 8'(fifo_dat_cnt - 1'b1);
      end

      if (cmd_hs) begin
        beat_q <= '0;
      end else if (wr_hs) begin
        beat_q <= beat_q + 8'd1;
      end

      if (last_hs) begin
        burst_cnt_q <= burst_cnt_q + 32'd1;
        addr_q      <= addr_next;
      end
    end
  end

  assign cmd_valid   = (state == CMD);
  assign cmd_addr    = addr_q;
  assign cmd_len     = len_q;
  assign wr_valid    = (state == DATA) && !fifo_rd_empty;
  assign wr_data     = fifo_rd_dat;
  assign wr_last     = wr_valid && (beat_q == len_q);
  assign fifo_rd_ena = wr_hs;
  assign busy        = (state != IDLE);
  assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: FWFT FIFO model, expected queues, negedge monitor.
module tb_fifo_burst_reader;

  localparam int DW = 128;
  localparam int AW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          enable;
  logic          fifo_rd_ena;
  logic [DW-1:0] fifo_rd_dat = '0;
  logic          fifo_rd_empty = 1'b1;
  logic [AW:0]   fifo_dat_cnt = '0;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;
  logic [31:0]   cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          busy;
  logic [31:0]   burst_cnt;

  fifo_burst_reader #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .BURST_LEN     (16),
    .MEM_ADDR_WIDTH(32),
    .REGION_BYTES  (512),
    .FLUSH_TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .fifo_rd_ena  (fifo_rd_ena),
    .fifo_rd_dat  (fifo_rd_dat),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_dat_cnt (fifo_dat_cnt),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .busy         (busy),
    .burst_cnt    (burst_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // FWFT FIFO model: pushes staged by stimulus, pops on fifo_rd_ena, outputs via NBA.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] push_q[$];
  logic          fifo_clear = 1'b0;

  always @(posedge clk) begin
    if (fifo_clear) begin
      fq.delete();
    end else if (fifo_rd_ena && fq.size() > 0) begin
      void'(fq.pop_front());
    end
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fifo_rd_empty <= (fq.size() == 0);
    fifo_dat_cnt  <= (AW + 1)'(fq.size());
    fifo_rd_dat   <= (fq.size() > 0) ? fq[0] : '0;
  end

  // Ready drivers: optional random wr_ready, cmd_ready after cmd_delay waiting cycles.
  bit rand_wr   = 1'b0;
  int cmd_delay = 0;
  int cmd_wait  = 0;

  always @(posedge clk) begin
    #1;
    wr_ready = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cmd_valid) cmd_wait++;
    else cmd_wait = 0;
    cmd_ready = (cmd_wait > cmd_delay);
  end

  // Scoreboard
  cmd_t          exp_cmd[$];
  beat_t         exp_beats[$];
  logic [DW-1:0] staged[$];
  int            seq = 0;
  int            beats_seen = 0;

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {32'hA000_0000 + 32'(seq), 32'(seq) * 32'd7, ~32'(seq), 32'(seq)};
      push_q.push_back(w);
      staged.push_back(w);
      seq++;
    end
  endtask

  task automatic expect_burst(input logic [31:0] addr, input int len);
    beat_t b;
    exp_cmd.push_back('{addr: addr, len: 8'(len)});
    for (int i = 0; i <= len; i++) begin
      b.data = staged.pop_front();
      b.last = (i == len);
      exp_beats.push_back(b);
    end
  endtask

  always @(negedge clk) begin : monitor
    cmd_t        c;
    beat_t       b;
    logic        held;
    logic [39:0] held_cmd;
    if (!rstn) begin
      held = 1'b0;
    end else begin
      if (cmd_valid) begin
        if (held) chk("cmd_stable", {cmd_addr, cmd_len}, held_cmd);
        if (cmd_ready) begin
          chk("cmd_expected", exp_cmd.size() != 0, 1);
          if (exp_cmd.size() != 0) begin
            c = exp_cmd.pop_front();
            chk("cmd_addr", cmd_addr, c.addr);
            chk("cmd_len", cmd_len, c.len);
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_cmd = {cmd_addr, cmd_len};
        end
      end else begin
        held = 1'b0;
      end
      if (wr_valid) chk("data_after_cmd", cmd_valid, 0);
      if (wr_valid && wr_ready) begin
        chk("pop_on_beat", fifo_rd_ena, 1);
        chk("beat_expected", exp_beats.size() != 0, 1);
        if (exp_beats.size() != 0) begin
          b = exp_beats.pop_front();
          chk("wr_data", wr_data, b.data);
          chk("wr_last", wr_last, b.last);
        end
        beats_seen++;
      end else if (fifo_rd_ena) begin
        chk("pop_without_beat", fifo_rd_ena, 0);
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_beats.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic watch_no_cmd(input string name, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= cmd_valid;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int n;
    rstn   = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {cmd_valid, wr_valid, wr_last, fifo_rd_ena, busy}, 0);
    chk("rst_addr", cmd_addr, 32'h0);
    chk("rst_len", cmd_len, 0);
    chk("rst_burst_cnt", burst_cnt, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // 15 words, one short of a burst: nothing may issue.
`ifdef FIFO_BURST_READER_FLUSH_EN
    enable = 1'b0;
`else
    enable = 1'b1;
`endif
    push_words(15);
    watch_no_cmd("no_partial_cmd", 100);
    chk("partial_busy", busy, 0);

    // 32 words total, readies tied high: bursts at 0x0 and 0x100.
    @(posedge clk); #1;
    push_words(17);
    expect_burst(32'h0, 15);
    expect_burst(32'h100, 15);
    enable = 1'b1;
    wait_done("two_bursts_done", 400);
    chk("burst_cnt_2", burst_cnt, 2);
    chk("fifo_drained_2", fq.size(), 0);

    // Random wr_ready, delayed cmd_ready; address wraps back to 0x0.
    rand_wr   = 1'b1;
    cmd_delay = 5;
    push_words(16);
    expect_burst(32'h0, 15);
    wait_done("stall_burst_done", 400);
    chk("burst_cnt_3", burst_cnt, 3);
    chk("fifo_drained_3", fq.size(), 0);
    rand_wr   = 1'b0;
    cmd_delay = 0;

    // Reset after beat 7 of a burst at 0x100.
    n = beats_seen;
    push_words(16);
    expect_burst(32'h100, 15);
    while (beats_seen < n + 7 && beats_seen < n + 1000) @(posedge clk);
    #1;
    rstn       = 1'b0;
    fifo_clear = 1'b1;
    #1;
    chk("midrst_ctrl", {cmd_valid, wr_valid, wr_last, fifo_rd_ena, busy}, 0);
    chk("midrst_addr", cmd_addr, 32'h0);
    chk("midrst_len", cmd_len, 0);
    chk("midrst_beats", beats_seen - n, 7);
    exp_cmd.delete();
    exp_beats.delete();
    staged.delete();
    @(posedge clk); #1;
    fifo_clear = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("postrst_burst_cnt", burst_cnt, 0);
    push_words(16);
    expect_burst(32'h0, 15);
    wait_done("postrst_burst_done", 400);
    chk("postrst_burst_cnt_1", burst_cnt, 1);
    chk("fifo_drained_4", fq.size(), 0);

    // Five residual words: flushed as a short burst only when the feature is built in.
    @(posedge clk); #1;
    push_words(5);
`ifdef FIFO_BURST_READER_FLUSH_EN
    expect_burst(32'h100, 4);
    n = 0;
    while (!cmd_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("flush_latency", n, 9);
    wait_done("flush_burst_done", 200);
    chk("flush_burst_cnt", burst_cnt, 2);
    chk("fifo_drained_5", fq.size(), 0);
`else
    watch_no_cmd("no_flush_cmd", 60);
    chk("residual_kept", fq.size(), 5);
    chk("residual_burst_cnt", burst_cnt, 1);
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
